instr_mem_writer: RTL and testbench
===================================

# instr_mem_writer

Serialising write-side counterpart of the instruction memory's fetch/decode path. It accepts one decoded Y86 instruction per handshake (icode, ifun, rA, rB, valC), determines its encoded length, and writes its bytes one per cycle, in the exact byte layout the fetch side decodes, into a byte-wide memory write port at an auto-incrementing address. It sits between the program loader/test harness and the instruction memory array. It also reports the next free address (next PC) after each instruction.

## Interface
- DATA_WID, 32: width of valC; the constant field occupies DATA_WID/8 bytes.
- ADDR_WID, 32: width of the write address and the address counter.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- addr_load  in  1  load the write pointer from load_addr; honoured only in IDLE.
- load_addr  in  ADDR_WID  new write-pointer value.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  block can accept an instruction.
- icode, ifun, rA, rB  in  4 each  instruction fields.
- valC  in  DATA_WID  constant field.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_WID  byte address.
- mem_data  out  8  byte value.
- done  out  1  one-cycle pulse on the last byte of an instruction.
- err  out  1  one-cycle pulse when an invalid icode is accepted.
- next_pc  out  ADDR_WID  current write pointer.

## Operation
- Byte layout: byte0 = {icode, ifun}; byte1 = {rA, rB}; then valC, least-significant byte first.
- Instruction length, with N = DATA_WID/8:
  - 1 byte: icode 0 (halt), 1 (nop), 9 (ret).
  - 2 bytes: icode 2, 6, A, B. Bytes 0-1.
  - 1+N bytes: icode 7 (jXX), 8 (call). Byte0, then valC; no register byte.
  - 2+N bytes: icode 3, 4, 5. Bytes 0-1, then valC.
  - icode C-F: invalid.
- FSM has two states, IDLE and EMIT. It holds a write pointer wr_ptr, a byte index idx, a latched length len and latched fields.
- IDLE:
  - in_ready = 1.
  - On in_valid with a valid icode: latch the fields and len, set idx = 0, go to EMIT.
  - On in_valid with an invalid icode: pulse err next cycle, write nothing, stay in IDLE, wr_ptr unchanged.
- EMIT:
  - in_ready = 0.
  - mem_we = 1, mem_addr = wr_ptr, mem_data = byte[idx].
  - Each cycle: wr_ptr += 1 and idx += 1.
  - When idx == len-1: done = 1 in that same cycle; next state is IDLE.
- addr_load in IDLE: wr_ptr <= load_addr.
  - If asserted in the same cycle as an accepted instruction, the load applies first and that instruction is written starting at load_addr.
  - addr_load is ignored in EMIT.
- wr_ptr wraps modulo 2^ADDR_WID with no error; bytes continue at address 0.
- Unused field nibbles are not checked (e.g. ifun of nop, rB of pushl); they are written as given.
- next_pc = wr_ptr at all times.

## Timing
- Reset values: state IDLE, wr_ptr 0, idx 0, mem_we 0, mem_addr 0, mem_data 0, done 0, err 0, next_pc 0.
  - in_ready is 0 during the reset cycle and 1 after it.
- Reset mid-EMIT aborts the instruction. No further bytes are written; already-written bytes remain in memory.
- Accept at edge T: byte k is presented in cycle T+1+k, for k = 0..len-1.
  - done is asserted in cycle T+len.
  - in_ready rises in cycle T+len+1.
  - Throughput is one instruction per len+1 cycles.
- err is asserted in cycle T+1 for an invalid accept at T; in_ready stays 1 throughout.
- All outputs are derived from registers only: no combinational path from inputs to outputs, except through in_ready.
- Fields and in_valid may change freely while in_ready = 0; they are not sampled.

## Test plan
- Reset, then halt (icode 0, ifun 0) -> one write: addr 0, data 0x00; done in the same cycle; next_pc = 1.
- irmovl: icode 3, ifun 0, rA F, rB 2, valC 0x12345678 -> six writes at addr 1..6: 30 F2 78 56 34 12; next_pc = 7; in_ready low for exactly 6 cycles.
- call, valC 0x00000100, after addr_load with load_addr = 0x40 in the same cycle as accept -> five writes at 0x40..0x44: 80 00 01 00 00; next_pc = 0x45.
- Invalid icode D -> err pulses once, mem_we stays 0, next_pc unchanged; a following nop is written at the unchanged address.
- With wr_ptr = 0xFFFFFFFF, write OPl (icode 6, ifun 1, rA 0, rB 3) -> data 61 at 0xFFFFFFFF, then 03 at 0x00000000; next_pc = 1.
- Assert rst in the third byte cycle of an rmmovl -> no writes after reset; all outputs reach their reset values; a following nop is written at addr 0.

Source files
------------

// File: rtl/instr_mem_writer_if.sv
// Instruction handshake bundle between the program loader (master) and
// instr_mem_writer (slave).
//   in_valid : master -> slave, instruction fields below are valid
//   in_ready : slave -> master, writer can take an instruction this cycle
//   icode, ifun, rA, rB : 4-bit decoded instruction fields
//   valC     : DATA_WID-bit constant field
interface instr_mem_writer_if #(
  parameter int unsigned DATA_WID = 32
);

  logic                in_valid;
  logic                in_ready;
  logic [3:0]          icode;
  logic [3:0]          ifun;
  logic [3:0]          rA;
  logic [3:0]          rB;
  logic [DATA_WID-1:0] valC;

  modport master (
    output in_valid,
    output icode,
    output ifun,
    output rA,
    output rB,
    output valC,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  icode,
    input  ifun,
    input  rA,
    input  rB,
    input  valC,
    output in_ready
  );

endinterface

// File: rtl/instr_mem_writer.sv
// Serialises one decoded Y86 instruction per handshake into a byte-wide
// memory write port at an auto-incrementing address, using the same byte
// layout the fetch stage decodes: {icode,ifun}, {rA,rB}, valC LSB first.
//
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   addr_load  : load write pointer from load_addr (IDLE only)
//   load_addr  : new write-pointer value
//   in_if      : instruction handshake (slave side)
//   mem_we     : byte write strobe
//   mem_addr   : byte address
//   mem_data   : byte value
//   done       : pulse on the last byte of an instruction
//   err        : pulse one cycle after an invalid icode is accepted
//   next_pc    : current write pointer
module instr_mem_writer #(
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned ADDR_WID = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                addr_load,
  input  logic [ADDR_WID-1:0] load_addr,
  instr_mem_writer_if.slave   in_if,
  output logic                mem_we,
  output logic [ADDR_WID-1:0] mem_addr,
  output logic [7:0]          mem_data,
  output logic                done,
  output logic                err,
  output logic [ADDR_WID-1:0] next_pc
);

  localparam int unsigned N_CONST = DATA_WID / 8;
  localparam int unsigned MAX_LEN = 2 + N_CONST;
  localparam int unsigned IDX_W   = $clog2(MAX_LEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_WID-1:0] wr_ptr;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    len_q;
  logic [3:0]          icode_q;
  logic [3:0]          ifun_q;
  logic [3:0]          ra_q;
  logic [3:0]          rb_q;
  logic [DATA_WID-1:0] valc_q;

  logic [IDX_W-1:0]    in_len_c;
  logic                last_c;

  // Encoded length in bytes; zero marks an invalid icode.
  function automatic logic [IDX_W-1:0] len_of(input logic [3:0] ic);
    logic [IDX_W-1:0] l;
    case (ic)
      4'h0, 4'h1, 4'h9:       l = IDX_W'(1);
      4'h2, 4'h6, 4'hA, 4'hB: l = IDX_W'(2);
      4'h7, 4'h8:             l = IDX_W'(1 + N_CONST);
      4'h3, 4'h4, 4'h5:       l = IDX_W'(2 + N_CONST);
      default:                l = '0;
    endcase
    return l;
  endfunction

  // jXX and call carry valC directly after byte 0 with no register byte.
  function automatic logic has_reg_byte(input logic [3:0] ic);
    return !((ic == 4'h7) || (ic == 4'h8));
  endfunction

  // Byte k of the encoded instruction.
  function automatic logic [7:0] byte_at(
    input logic [3:0]          ic,
    input logic [3:0]          fn,
    input logic [3:0]          ra,
    input logic [3:0]          rb,
    input logic [DATA_WID-1:0] c,
    input logic [IDX_W-1:0]    k
  );
    logic [IDX_W-1:0] j;
    logic [7:0]       b;
    j = '0;
    if (k == '0) begin
      b = {ic, fn};
    end else if (has_reg_byte(ic) && (k == IDX_W'(1))) begin
      b = {ra, rb};
    end else begin
      j = has_reg_byte(ic) ? (k - IDX_W'(2)) : (k - IDX_W'(1));
      b = 8'(c >> (8 * j));
    end
    return b;
  endfunction

  assign in_len_c = len_of(in_if.icode);
  assign last_c   = (idx == (len_q - IDX_W'(1)));

  // Ready only in IDLE and never while reset is held.
  assign in_if.in_ready = (state == IDLE) && !rst;

  // The write pointer is the live address during EMIT and the next free
  // address otherwise.
  assign mem_addr = wr_ptr;
  assign next_pc  = wr_ptr;

  // Control FSM, pointer, latched fields and registered byte outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      idx      <= '0;
      len_q    <= '0;
      icode_q  <= '0;
      ifun_q   <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      valc_q   <= '0;
      mem_we   <= 1'b0;
      mem_data <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          // A load in the accept cycle lands first, so the instruction
          // starts at load_addr.
          if (addr_load) begin
            wr_ptr <= load_addr;
          end
          if (in_if.in_valid) begin
            if (in_len_c == '0) begin
              err <= 1'b1;
            end else begin
              icode_q  <= in_if.icode;
              ifun_q   <= in_if.ifun;
              ra_q     <= in_if.rA;
              rb_q     <= in_if.rB;
              valc_q   <= in_if.valC;
              len_q    <= in_len_c;
              idx      <= '0;
              state    <= EMIT;
              mem_we   <= 1'b1;
              mem_data <= byte_at(in_if.icode, in_if.ifun, in_if.rA,
                                  in_if.rB, in_if.valC, '0);
              done     <= (in_len_c == IDX_W'(1));
            end
          end
        end
        EMIT: begin
          wr_ptr <= wr_ptr + ADDR_WID'(1);
          if (last_c) begin
            state <= IDLE;
          end else begin
            idx      <= idx + IDX_W'(1);
            mem_we   <= 1'b1;
            mem_data <= byte_at(icode_q, ifun_q, ra_q, rb_q, valc_q,
                                idx + IDX_W'(1));
            done     <= ((idx + IDX_W'(1)) == (len_q - IDX_W'(1)));
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_writer.sv
module tb_instr_mem_writer;

  typedef struct {
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] valc;
    logic        load;
    logic [31:0] laddr;
    int          exp_len;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    logic        last;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_load = 1'b0;
  logic [31:0] load_addr = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        done;
  logic        err;
  logic [31:0] next_pc;

  int checks = 0;
  int failures = 0;

  wr_t         sbq[$];
  logic [31:0] exp_ptr = '0;
  vec_t        vecs[15];

  instr_mem_writer_if #(.DATA_WID(32)) in_if ();

  instr_mem_writer #(.DATA_WID(32), .ADDR_WID(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_load (addr_load),
    .load_addr (load_addr),
    .in_if     (in_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .done      (done),
    .err       (err),
    .next_pc   (next_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference encoder: layout chosen from the expected length.
  function automatic logic [7:0] model_byte(input vec_t v, input int k);
    logic [31:0] c;
    int j;
    c = v.valc;
    if (k == 0) return {v.ic, v.fn};
    if (v.exp_len == 5) begin
      j = k - 1;
    end else begin
      if (k == 1) return {v.ra, v.rb};
      j = k - 2;
    end
    return c[8*j +: 8];
  endfunction

  function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [31:0] valc, input logic load,
                              input logic [31:0] laddr, input int len,
                              input logic e);
    vec_t v;
    v.ic = ic; v.fn = fn; v.ra = ra; v.rb = rb; v.valc = valc;
    v.load = load; v.laddr = laddr; v.exp_len = len; v.exp_err = e;
    return v;
  endfunction

  // Scoreboard: every write is matched against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                   mem_addr, mem_data);
        end else begin
          wr_t e;
          e = sbq.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_data), 64'(e.data));
          chk("wr_done", 64'(done), 64'(e.last));
        end
      end else if (done) begin
        chk("done_without_write", 64'(done), 64'd0);
      end
    end
  end

  // Present one instruction; returns one cycle after the accepting edge.
  task automatic accept(input vec_t v);
    in_if.icode    = v.ic;
    in_if.ifun     = v.fn;
    in_if.rA       = v.ra;
    in_if.rB       = v.rb;
    in_if.valC     = v.valc;
    in_if.in_valid = 1'b1;
    addr_load      = v.load;
    load_addr      = v.laddr;
    #1;
    chk("ready_before_accept", 64'(in_if.in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b0;
    addr_load      = 1'b0;
    in_if.icode    = 4'($urandom);
    in_if.valC     = $urandom;
  endtask

  // Counts busy cycles; while busy, hammers in_valid/addr_load to show
  // they are ignored outside IDLE.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_if.in_ready) begin
        in_if.in_valid = 1'b0;
        addr_load      = 1'b0;
        return;
      end
      n++;
      in_if.in_valid = 1'b1;
      in_if.icode    = 4'($urandom);
      in_if.rA       = 4'($urandom);
      addr_load      = 1'b1;
      load_addr      = $urandom;
    end
    in_if.in_valid = 1'b0;
    addr_load      = 1'b0;
    checks++;
    failures++;
    $display("FAIL ready_timeout actual=busy after %0d cycles required=idle", n);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    if (v.load) exp_ptr = v.laddr;
    if (!v.exp_err) begin
      for (int k = 0; k < v.exp_len; k++) begin
        wr_t w;
        w.addr = exp_ptr + 32'(k);
        w.data = model_byte(v, k);
        w.last = (k == v.exp_len - 1);
        sbq.push_back(w);
      end
    end
    accept(v);
    if (v.exp_err) begin
      @(negedge clk);
      chk({name, "_err_pulse"}, 64'(err), 64'd1);
      chk({name, "_err_ready"}, 64'(in_if.in_ready), 64'd1);
      @(negedge clk);
      chk({name, "_err_clear"}, 64'(err), 64'd0);
      chk({name, "_err_ready2"}, 64'(in_if.in_ready), 64'd1);
    end else begin
      wait_idle(n);
      chk({name, "_busy_cycles"}, 64'(n), 64'(v.exp_len));
      exp_ptr = exp_ptr + 32'(v.exp_len);
    end
    chk({name, "_next_pc"}, 64'(next_pc), 64'(exp_ptr));
    chk({name, "_queue_empty"}, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    vecs[0]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 32'h0,        1'b0, 32'h0,        1, 1'b0); // halt
    vecs[1]  = mk(4'h3, 4'h0, 4'hF, 4'h2, 32'h12345678, 1'b0, 32'h0,        6, 1'b0); // irmovl
    vecs[2]  = mk(4'h8, 4'h0, 4'h0, 4'h0, 32'h00000100, 1'b1, 32'h40,       5, 1'b0); // call + load
    vecs[3]  = mk(4'hD, 4'h0, 4'h1, 4'h2, 32'h55,       1'b0, 32'h0,        0, 1'b1); // invalid
    vecs[4]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 32'h0,        1'b0, 32'h0,        1, 1'b0); // nop
    vecs[5]  = mk(4'h4, 4'h0, 4'h1, 4'h2, 32'hDEADBEEF, 1'b0, 32'h0,        6, 1'b0); // rmmovl
    vecs[6]  = mk(4'h5, 4'h0, 4'h3, 4'h4, 32'h00000000, 1'b0, 32'h0,        6, 1'b0); // mrmovl
    vecs[7]  = mk(4'h7, 4'h3, 4'h9, 4'h9, 32'hCAFEF00D, 1'b0, 32'h0,        5, 1'b0); // jXX
    vecs[8]  = mk(4'h9, 4'h0, 4'h0, 4'h0, 32'h0,        1'b0, 32'h0,        1, 1'b0); // ret
    vecs[9]  = mk(4'h2, 4'h4, 4'h1, 4'h2, 32'h0,        1'b0, 32'h0,        2, 1'b0); // cmovXX
    vecs[10] = mk(4'hA, 4'h0, 4'h6, 4'hF, 32'h0,        1'b0, 32'h0,        2, 1'b0); // pushl
    vecs[11] = mk(4'hB, 4'h0, 4'h6, 4'hF, 32'h0,        1'b0, 32'h0,        2, 1'b0); // popl
    vecs[12] = mk(4'hF, 4'h7, 4'h1, 4'h1, 32'h0,        1'b0, 32'h0,        0, 1'b1); // invalid
    vecs[13] = mk(4'hC, 4'h0, 4'h0, 4'h0, 32'h0,        1'b1, 32'h200,      0, 1'b1); // invalid + load
    vecs[14] = mk(4'h6, 4'h1, 4'h0, 4'h3, 32'h0,        1'b1, 32'hFFFFFFFF, 2, 1'b0); // OPl wrap

    in_if.in_valid = 1'b0;
    in_if.icode = '0; in_if.ifun = '0; in_if.rA = '0; in_if.rB = '0; in_if.valC = '0;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready", 64'(in_if.in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_data", 64'(mem_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_next_pc", 64'(next_pc), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_if.in_ready), 64'd1);

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the third byte of an rmmovl: only bytes 0 and 1 count.
    begin
      wr_t w;
      vec_t v;
      v = mk(4'h4, 4'h0, 4'h7, 4'h5, 32'hA1B2C3D4, 1'b1, 32'h80, 6, 1'b0);
      w.addr = 32'h80; w.data = 8'h40; w.last = 1'b0; sbq.push_back(w);
      w.addr = 32'h81; w.data = 8'h75; w.last = 1'b0; sbq.push_back(w);
      accept(v);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready_low", 64'(in_if.in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mid_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mid_mem_data", 64'(mem_data), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_err", 64'(err), 64'd0);
      chk("rst_mid_next_pc", 64'(next_pc), 64'd0);
      chk("rst_mid_ready", 64'(in_if.in_ready), 64'd1);
      chk("rst_mid_queue", 64'(sbq.size()), 64'd0);
      sbq.delete();
      repeat (3) @(negedge clk);
      exp_ptr = '0;
      v = mk(4'h1, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1, 1'b0);
      w.addr = 32'h0; w.data = 8'h10; w.last = 1'b1; sbq.push_back(w);
      exp_ptr = 32'h0 - 32'h1;
      v.exp_len = 1;
      accept(v);
      begin
        int n;
        wait_idle(n);
        chk("nop_after_rst_busy", 64'(n), 64'd1);
      end
      chk("nop_after_rst_next_pc", 64'(next_pc), 64'd1);
      chk("nop_after_rst_queue", 64'(sbq.size()), 64'd0);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
